// File: rtl/apb_seq_pkg.sv
// Shared types and constants for the APB transfer sequencer and its helpers.
package apb_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } seq_state_t;

    localparam int         NUM_SLAVES         = 3;
    localparam logic [1:0] UNMAPPED_REGION    = 2'd3;
    localparam int         DEF_SEL_LSB        = 8;
    localparam int         DEF_TIMEOUT_CYCLES = 16;
    localparam int         DEF_CNT_W          = 5;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the 2-bit address region field to a one-hot APB select.
// Region 3 has no slave behind it and is flagged as unmapped.
module apb_addr_decoder
    import apb_seq_pkg::*;
(
    input  logic [1:0]            i_region,
    output logic [NUM_SLAVES-1:0] o_sel,
    output logic                  o_unmapped
);

    // One-hot select per region; the unmapped region selects nothing.
    always_comb begin
        o_sel      = '0;
        o_unmapped = 1'b0;
        case (i_region)
            2'd0:    o_sel = 3'b001;
            2'd1:    o_sel = 3'b010;
            2'd2:    o_sel = 3'b100;
            default: o_unmapped = (i_region == UNMAPPED_REGION);
        endcase
    end

endmodule

// File: rtl/apb_transfer_sequencer.sv
// APB master-side sequencer: accepts one request at a time, runs the
// SETUP/ACCESS phases and returns a single-cycle response. Unmapped
// regions and slaves that never raise Pready end with an error response.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a request; Pselx=0, Paddr/Pwrite keep last value
// ST_SETUP  | Pselx asserted, Penable low, one cycle only
// ST_ACCESS | Penable high, waiting on Pready or timeout
module apb_transfer_sequencer
    import apb_seq_pkg::*;
#(
    parameter int SEL_LSB        = DEF_SEL_LSB,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        Pwrite,
    output logic        Penable,
    output logic [2:0]  Pselx,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    input  logic        Pready,
    input  logic [31:0] Prdata,
    input  logic        Pslverr
);

    // The counter starts at 0 in the first ACCESS cycle, so the abort fires
    // on the edge that closes ACCESS cycle number TIMEOUT_CYCLES.
    localparam int               TO_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
    localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

    seq_state_t  r_state;
    logic [CNT_W-1:0] r_cnt;
    logic        r_pwrite;
    logic        r_penable;
    logic [2:0]  r_pselx;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic [2:0]  w_sel;
    logic        w_unmapped;
    logic        w_timeout;

    apb_addr_decoder u_addr_decoder (
        .i_region   (req_addr[SEL_LSB+1:SEL_LSB]),
        .o_sel      (w_sel),
        .o_unmapped (w_unmapped)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign w_timeout = TO_EN && (r_cnt == CNT_LAST);

    assign Pwrite    = r_pwrite;
    assign Penable   = r_penable;
    assign Pselx     = r_pselx;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

    // Phase sequencing, APB drive and response generation.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pwrite    <= 1'b0;
            r_penable   <= 1'b0;
            r_pselx     <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_pwrite <= req_write;
                        r_paddr  <= req_addr;
                        r_pwdata <= req_write ? req_wdata : 32'h0;
                        if (w_unmapped) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_pselx <= w_sel;
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (Pready) begin
                        r_pselx     <= '0;
                        r_penable   <= 1'b0;
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= Pslverr;
                        r_rsp_rdata <= (!r_pwrite && !Pslverr) ? Prdata : 32'h0;
                    end else if (w_timeout) begin
                        r_pselx     <= '0;
                        r_penable   <= 1'b0;
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_pselx   <= '0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_transfer_sequencer.sv
// Self-checking bench for apb_transfer_sequencer: directed cases followed by
// randomized transfers, each checked cycle by cycle against expectations
// derived from the transfer's region, slave wait count and error flag.
module tb_apb_transfer_sequencer;

    localparam int TO = 16;

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        Pwrite;
    logic        Penable;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pready = 1'b0;
    logic [31:0] Prdata = '0;
    logic        Pslverr = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Hclk = ~Hclk;

    apb_transfer_sequencer #(
        .SEL_LSB        (8),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (5)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .Pwrite    (Pwrite),
        .Penable   (Penable),
        .Pselx     (Pselx),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Pready    (Pready),
        .Prdata    (Prdata),
        .Pslverr   (Pslverr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    // One transfer: handshake, act as the slave (Pready after d wait cycles),
    // and check every cycle up to and including the response cycle.
    // Returns in the response cycle so the next call is back-to-back.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int d, input logic serr, input logic [31:0] rd, input int gap);
        logic [1:0]  region;
        logic        unm;
        logic        tmo;
        int          fin;
        logic [2:0]  sel;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_wd;
        region  = addr[9:8];
        unm     = (region == 2'd3);
        tmo     = !unm && (d >= TO);
        fin     = unm ? 0 : 2 + ((d < TO) ? d : TO - 1);
        sel     = unm ? 3'b000 : (3'b001 << region);
        exp_rd  = (!unm && !tmo && !wr && !serr) ? rd : 32'h0;
        exp_err = unm || tmo || serr;
        exp_wd  = wr ? wd : 32'h0;

        check("req_ready_idle", {31'b0, req_ready}, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;

        for (int k = 0; k <= fin; k++) begin
            if (k > 0) tick();
            if (k < fin) begin
                check("pselx_busy",  {29'b0, Pselx}, {29'b0, sel});
                check("penable",     {31'b0, Penable}, (k >= 1) ? 1 : 0);
                check("rsp_quiet",   {31'b0, rsp_valid}, 0);
                check("req_ready_busy", {31'b0, req_ready}, 0);
                check("paddr",       Paddr, addr);
                check("pwrite",      {31'b0, Pwrite}, {31'b0, wr});
                check("pwdata",      Pwdata, exp_wd);
                Pready  = (k >= 1) && (k == d + 1);
                Prdata  = Pready ? rd : $urandom;
                Pslverr = Pready ? serr : 1'($urandom_range(0, 1));
            end else begin
                Pready  = 1'b0;
                Pslverr = 1'b0;
                check("rsp_valid",     {31'b0, rsp_valid}, 1);
                check("rsp_err",       {31'b0, rsp_err}, {31'b0, exp_err});
                check("rsp_rdata",     rsp_rdata, exp_rd);
                check("pselx_done",    {29'b0, Pselx}, 0);
                check("penable_done",  {31'b0, Penable}, 0);
                check("req_ready_rsp", {31'b0, req_ready}, 1);
            end
        end

        for (int g = 0; g < gap; g++) begin
            tick();
            check("rsp_pulse_end", {31'b0, rsp_valid}, 0);
            check("pselx_idle",    {29'b0, Pselx}, 0);
            check("penable_idle",  {31'b0, Penable}, 0);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        int          dly;

        #2 Hresetn = 1'b0;
        repeat (3) @(posedge Hclk);
        #1;
        check("rst_pselx",     {29'b0, Pselx}, 0);
        check("rst_penable",   {31'b0, Penable}, 0);
        check("rst_pwrite",    {31'b0, Pwrite}, 0);
        check("rst_paddr",     Paddr, 0);
        check("rst_pwdata",    Pwdata, 0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_rsp_err",   {31'b0, rsp_err}, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_req_ready", {31'b0, req_ready}, 1);
        Hresetn = 1'b1;
        tick();

        // read region 1, immediate ready
        xfer(1'b0, 32'h0000_0104, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1);
        // write region 0, three wait cycles
        xfer(1'b1, 32'h0000_0010, 32'h1234_5678, 3, 1'b0, 32'hA5A5_A5A5, 1);
        // unmapped region
        xfer(1'b0, 32'h0000_0300, 32'h0, 0, 1'b0, 32'h1111_1111, 1);
        // slave never ready: timeout abort
        xfer(1'b0, 32'h0000_0204, 32'h0, 40, 1'b0, 32'h2222_2222, 1);
        // ready on the last allowed access cycle: normal completion
        xfer(1'b1, 32'h0000_0120, 32'hCAFE_F00D, TO - 1, 1'b0, 32'h3333_3333, 1);
        xfer(1'b0, 32'h0000_0140, 32'h0, TO - 1, 1'b0, 32'h4444_4444, 1);
        // slave error on region 2, followed back-to-back by another request
        xfer(1'b0, 32'h0000_02F0, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 0);
        xfer(1'b1, 32'h0000_01AC, 32'h5555_AAAA, 2, 1'b0, 32'h0, 0);
        xfer(1'b0, 32'h0000_0300, 32'h0, 0, 1'b0, 32'h0, 0);
        xfer(1'b0, 32'h0000_0008, 32'h0, 1, 1'b0, 32'h0BAD_CAFE, 1);

        // reset pulse in the middle of an ACCESS phase
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0108;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("pre_rst_pselx",   {29'b0, Pselx}, 3'b010);
        check("pre_rst_penable", {31'b0, Penable}, 1);
        #2 Hresetn = 1'b0;
        #1;
        check("midrst_pselx",     {29'b0, Pselx}, 0);
        check("midrst_penable",   {31'b0, Penable}, 0);
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
        tick();
        check("midrst_rsp_hold",  {31'b0, rsp_valid}, 0);
        Hresetn = 1'b1;
        tick();
        check("postrst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("postrst_pselx",     {29'b0, Pselx}, 0);
        xfer(1'b0, 32'h0000_0200, 32'h0, 2, 1'b0, 32'h7777_0001, 1);

        // randomized transfers
        for (int n = 0; n < 60; n++) begin
            a      = $urandom;
            a[9:8] = 2'($urandom_range(0, 3));
            r      = $urandom_range(0, 9);
            if (r < 6)      dly = $urandom_range(0, 4);
            else if (r < 8) dly = $urandom_range(5, 17);
            else            dly = $urandom_range(14, 20);
            xfer(1'($urandom_range(0, 1)), a, $urandom, dly,
                 1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
